// File: rtl/rv32i_types.sv
// Shared types for the RV32I pipeline control path.
// Latency: n/a (types only).
// Backpressure: n/a.
package rv32i_types;

    localparam int REG_IDX_W = 5;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } pctrl_state_t;

    // Per-cycle pipeline-register control word produced by pipeline_ctrl.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_bubble;
        logic id_ex_bubble;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FLOW  = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                          ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                          if_id_bubble: 1'b0, id_ex_bubble: 1'b0,
                                          mem_wb_bubble: 1'b0};
    localparam pipe_ctrl_t CTRL_RESET = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
                                          ex_mem_en: 1'b0, mem_wb_en: 1'b0,
                                          if_id_bubble: 1'b1, id_ex_bubble: 1'b1,
                                          mem_wb_bubble: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: ID reads a register that the load now in EX will write.
// Latency: purely combinational, same cycle.
// Backpressure: none; consumer (pipeline_ctrl) applies the stall.
module load_use_detect
    import rv32i_types::*;
(
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_valid,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = id_valid && ex_valid && ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline; drops the wrong-path fetch after a redirect.
// Latency: enables/bubbles combinational in the same cycle; FSM and perf counters registered.
// Backpressure: D-cache miss freezes everything, I-cache miss bubbles IF/ID, load-use holds IF/ID.
//
// Ports: clk, rst (async active-low); ID/EX hazard fields, mispredict, imem/dmem handshake in;
// pc_en, per-stage *_en / *_bubble, redirect_pending out.
// Optional PIPELINE_CTRL_PERF_EN adds perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt.
module pipeline_ctrl
    import rv32i_types::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_valid,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 mispredict,
    input  logic                 imem_req,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_bubble,
    output logic                 id_ex_bubble,
    output logic                 mem_wb_bubble,
    output logic                 redirect_pending
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_bubble_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    pctrl_state_t state_q;
    pctrl_state_t state_d;
    pipe_ctrl_t   ctrl;
    logic         load_use;
    logic         mem_stall;
    logic         imem_stall;
    logic         redirect;
    logic         draining;

    load_use_detect u_load_use_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    assign mem_stall  = dmem_req && !dmem_resp;
    assign imem_stall = imem_req && !imem_resp;
    // EX is frozen during a D-cache miss, so the mispredict is acted on once it clears.
    assign redirect   = mispredict && !mem_stall;
    assign draining   = (state_q == DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_FLOW;

        unique case (state_q)
            RUN:     if (redirect && imem_stall) state_d = DRAIN;
            // A newer redirect while draining just refreshes the target in the fetch
            // unit; the only exit is the wrong-path response, even under a D-cache freeze.
            DRAIN:   if (imem_resp) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (mem_stall) begin
            ctrl               = '0;
            ctrl.mem_wb_bubble = 1'b1;
            ctrl.if_id_bubble  = draining;
        end else if (redirect) begin
            ctrl.if_id_bubble = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
        end else if (load_use) begin
            // Load-use outranks an I-cache miss: IF/ID must hold the dependent instruction.
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
            ctrl.if_id_bubble = draining;
        end else if (draining) begin
            // Whatever fetch data lands now is wrong-path; the response cycle launches the
            // redirected fetch.
            ctrl.pc_en        = imem_resp;
            ctrl.if_id_bubble = 1'b1;
        end else if (imem_stall) begin
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_bubble = 1'b1;
        end

        if (!rst) begin
            ctrl = CTRL_RESET;
        end
    end

    assign pc_en            = ctrl.pc_en;
    assign if_id_en         = ctrl.if_id_en;
    assign id_ex_en         = ctrl.id_ex_en;
    assign ex_mem_en        = ctrl.ex_mem_en;
    assign mem_wb_en        = ctrl.mem_wb_en;
    assign if_id_bubble     = ctrl.if_id_bubble;
    assign id_ex_bubble     = ctrl.id_ex_bubble;
    assign mem_wb_bubble    = ctrl.mem_wb_bubble;
    assign redirect_pending = draining;

`ifdef PIPELINE_CTRL_PERF_EN
    // Count only load-use cycles that actually insert the bubble (not masked by a
    // freeze or a flush), so one hazard counts once.
    logic bubble_evt;
    assign bubble_evt = load_use && !mem_stall && !redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (mem_stall || imem_stall) perf_stall_cnt  <= perf_stall_cnt + 32'd1;
            if (bubble_evt)              perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (redirect)                perf_flush_cnt  <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a rule-table model.
// Output vector order: {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_b,id_ex_b,mem_wb_b,redirect_pending}.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       mispredict, imem_req, imem_resp, dmem_req, dmem_resp;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_bubble, id_ex_bubble, mem_wb_bubble, redirect_pending;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Model state
    bit          m_drain = 1'b0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_bub   = '0;
    logic [31:0] m_flush = '0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs1      (id_uses_rs1),
        .id_uses_rs2      (id_uses_rs2),
        .ex_valid         (ex_valid),
        .ex_is_load       (ex_is_load),
        .ex_rd            (ex_rd),
        .mispredict       (mispredict),
        .imem_req         (imem_req),
        .imem_resp        (imem_resp),
        .dmem_req         (dmem_req),
        .dmem_resp        (dmem_resp),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .id_ex_en         (id_ex_en),
        .ex_mem_en        (ex_mem_en),
        .mem_wb_en        (mem_wb_en),
        .if_id_bubble     (if_id_bubble),
        .id_ex_bubble     (id_ex_bubble),
        .mem_wb_bubble    (mem_wb_bubble),
        .redirect_pending (redirect_pending)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_bubble_cnt  (perf_bubble_cnt),
        .perf_flush_cnt   (perf_flush_cnt)
`endif
    );

    function automatic logic [8:0] dut_outs();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_bubble, id_ex_bubble, mem_wb_bubble, redirect_pending};
    endfunction

    function automatic bit m_hazard();
        return id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    // Rule table: first matching row gives the whole output vector.
    function automatic logic [8:0] model_outs();
        bit ms, is, rd;
        ms = dmem_req && !dmem_resp;
        is = imem_req && !imem_resp;
        rd = mispredict && !ms;
        if (!rst)       return 9'b00000_111_0;
        if (ms)         return {5'b00000, m_drain, 2'b01, m_drain};
        if (rd)         return {5'b11111, 3'b110, m_drain};
        if (m_hazard()) return {5'b00111, m_drain, 2'b10, m_drain};
        if (m_drain)    return {imem_resp, 4'b1111, 3'b100, 1'b1};
        if (is)         return 9'b01111_100_0;
        return 9'b11111_000_0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
    endtask

    task automatic sample();
        @(negedge clk);
        check("model_outs", 32'(dut_outs()), 32'(model_outs()));
`ifdef PIPELINE_CTRL_PERF_EN
        check("model_stall_cnt", perf_stall_cnt, m_stall);
        check("model_bubble_cnt", perf_bubble_cnt, m_bub);
        check("model_flush_cnt", perf_flush_cnt, m_flush);
`endif
    endtask

    task automatic advance();
        bit ms, is, rd;
        @(posedge clk);
        ms = dmem_req && !dmem_resp;
        is = imem_req && !imem_resp;
        rd = mispredict && !ms;
        if (!rst) begin
            m_drain = 1'b0;
            m_stall = '0;
            m_bub   = '0;
            m_flush = '0;
        end else begin
            if (ms || is)                 m_stall = m_stall + 1;
            if (m_hazard() && !ms && !rd) m_bub   = m_bub + 1;
            if (rd)                       m_flush = m_flush + 1;
            m_drain = m_drain ? !imem_resp : (rd && is);
        end
        #1;
    endtask

    task automatic step_lit(input string name, input logic [8:0] want);
        sample();
        check(name, 32'(dut_outs()), 32'(want));
        advance();
    endtask

    task automatic idle_in();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0;
        mispredict = 0; imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    endtask

    task automatic set_load_use();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5;
        id_valid = 1; id_rs1 = 5'd5; id_rs2 = 5'd1; id_uses_rs1 = 1; id_uses_rs2 = 1;
    endtask

    initial begin
        idle_in();
        rst = 1'b0;
        #1;
        step_lit("reset_state", 9'b00000_111_0);
        rst = 1'b1;
        step_lit("idle_flow", 9'b11111_000_0);

        // lw x5 in EX, add x6,x5,x1 in ID: one bubble, then normal flow
        set_load_use();
        step_lit("load_use_stall", 9'b00111_010_0);
        ex_is_load = 0; ex_rd = 5'd6; id_rs1 = 5'd7; id_rs2 = 5'd8;
        step_lit("load_use_release", 9'b11111_000_0);

        // lw x0 with ID reading x0: no hazard
        set_load_use();
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        step_lit("x0_no_stall", 9'b11111_000_0);

        // D-cache miss for 4 cycles
        idle_in();
        dmem_req = 1;
        for (int i = 0; i < 4; i++) step_lit("dmiss_freeze", 9'b00000_001_0);
        dmem_resp = 1;
        step_lit("dmiss_release", 9'b11111_000_0);

        // Mispredict with fetch outstanding -> DRAIN, response on the third cycle
        idle_in();
        mispredict = 1; imem_req = 1;
        step_lit("redirect_into_drain", 9'b11111_110_0);
        mispredict = 0;
        step_lit("drain_wait1", 9'b01111_100_1);
        step_lit("drain_wait2", 9'b01111_100_1);
        imem_resp = 1;
        step_lit("drain_resp_discard", 9'b11111_100_1);
        idle_in();
        step_lit("drain_back_to_run", 9'b11111_000_0);

        // Mispredict + load-use: redirect only
        set_load_use();
        mispredict = 1;
        step_lit("prio_redirect_over_lu", 9'b11111_110_0);
        // Mispredict + D-cache miss: freeze, redirect once the miss resolves
        idle_in();
        mispredict = 1; dmem_req = 1;
        step_lit("prio_freeze1", 9'b00000_001_0);
        step_lit("prio_freeze2", 9'b00000_001_0);
        dmem_resp = 1;
        step_lit("prio_redirect_after_miss", 9'b11111_110_0);

        // Reset in the middle of DRAIN
        idle_in();
        mispredict = 1; imem_req = 1;
        step_lit("redirect_into_drain2", 9'b11111_110_0);
        mispredict = 0;
        step_lit("drain_again", 9'b01111_100_1);
        rst = 1'b0;
        sample();
        check("reset_mid_drain", 32'(dut_outs()), 32'(9'b00000_111_0));
`ifdef PIPELINE_CTRL_PERF_EN
        check("reset_stall_cnt_zero", perf_stall_cnt, 32'd0);
        check("reset_flush_cnt_zero", perf_flush_cnt, 32'd0);
`endif
        advance();
        rst = 1'b1;
        step_lit("post_reset_run_imiss", 9'b01111_100_0);

        // Randomized traffic, checked every cycle against the model
        for (int c = 0; c < 3000; c++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_uses_rs1 = ($urandom_range(0, 1) != 0);
            id_uses_rs2 = ($urandom_range(0, 1) != 0);
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_is_load  = ($urandom_range(0, 1) != 0);
            ex_rd       = 5'($urandom_range(0, 3));
            mispredict  = ($urandom_range(0, 7) == 0);
            imem_req    = ($urandom_range(0, 1) != 0);
            imem_resp   = imem_req && ($urandom_range(0, 2) == 0);
            dmem_req    = ($urandom_range(0, 2) == 0);
            dmem_resp   = dmem_req && ($urandom_range(0, 1) != 0);
            rst         = ($urandom_range(0, 149) != 0);
            sample();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
